spi_master_ctrl: RTL and testbench

SPI master transfer sequencer for the SPI peripheral. Takes one DATA_W-bit word per valid/ready handshake. Generates SPI_CLK, SPI_CS_n and SPI_MOSI in SPI mode 0 (CPOL=0, CPHA=0), MSB first, and returns the word sampled on SPI_MISO. Runs its own integer divider internally off the peripheral clock and replaces the free-running divider as the SPI clock source.

---
 rtl/spi_master_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 (CPOL=0, CPHA=0) MSB-first master sequencer.
// Accepts one word per valid/ready handshake, paces SPI_CLK from PClK with
// its own half-period divider, and returns the word sampled on SPI_MISO.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              PClK,
  input  logic              PRESETn,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              SPI_CLK,
  output logic              SPI_CS_n,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [EDGE_W-1:0] EDGE_PRE  = EDGE_W'(2 * DATA_W - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   txsh_q, txsh_d;
  logic [DATA_W-1:0]   rxsh_q, rxsh_d;
  logic [DATA_W-1:0]   rxdata_q, rxdata_d;
  logic                rxvalid_q, rxvalid_d;
  logic                sclk_q, sclk_d;
  logic                csn_q, csn_d;
  logic                mosi_q, mosi_d;

  logic tick;
  logic handshake;

  assign tick      = (div_q == DIV_LAST);
  assign handshake = tx_valid && (state_q == IDLE);

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rx_valid = rxvalid_q;
  assign rx_data  = rxdata_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_CS_n = csn_q;
  assign SPI_MOSI = mosi_q;

  // Half-period divider: held at zero while idle so each frame starts on a fresh count.
  always_comb begin
    div_d = div_q;
    if (state_q == IDLE) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Frame sequencing: every SPI edge and phase change is taken on a divider tick.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    txsh_d    = txsh_q;
    rxsh_d    = rxsh_q;
    rxdata_d  = rxdata_q;
    rxvalid_d = 1'b0;
    sclk_d    = sclk_q;
    csn_d     = csn_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          txsh_d  = tx_data;
          rxsh_d  = '0;
          mosi_d  = tx_data[DATA_W-1];
          csn_d   = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          state_d = XFER;
          edge_d  = '0;
          sclk_d  = 1'b1;
          rxsh_d  = {rxsh_q[DATA_W-2:0], SPI_MISO};
        end
      end

      XFER: begin
        if (tick) begin
          if (edge_q == EDGE_LAST) begin
            state_d = HOLD;
          end else begin
            edge_d = edge_q + EDGE_W'(1);
            if (edge_q[0]) begin
              sclk_d = 1'b1;
              rxsh_d = {rxsh_q[DATA_W-2:0], SPI_MISO};
            end else begin
              sclk_d = 1'b0;
              if (edge_q != EDGE_PRE) begin
                mosi_d = txsh_q[DATA_W-2];
                txsh_d = {txsh_q[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          csn_d     = 1'b1;
          rxdata_d  = rxsh_q;
          rxvalid_d = 1'b1;
          state_d   = GAP;
        end
      end

      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        csn_d   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset drops CS and discards any partial word at once.
  always_ff @(posedge PClK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      txsh_q    <= '0;
      rxsh_q    <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      sclk_q    <= 1'b0;
      csn_q     <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      txsh_q    <= txsh_d;
      rxsh_q    <= rxsh_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      sclk_q    <= sclk_d;
      csn_q     <= csn_d;
      mosi_q    <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: self-checking bench for spi_master_ctrl. A frame-level
// model predicts every output from the handshake cycle and the captured word;
// directed frames pin literal timings and data, then random traffic runs.
module tb_spi_master_ctrl;

  localparam int DW  = 8;
  localparam int CD  = 4;
  localparam int L   = (2 * DW + 3) * CD;
  localparam int RXT = (2 * DW + 2) * CD;

  logic       PClK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       txValid = 1'b0;
  logic [7:0] txData = '0;
  logic       txReady, rxValid, busy, spiClk, spiCsN, spiMosi, spiMiso;
  logic [7:0] rxData;
  logic       loopMode = 1'b1;
  logic       misoDrv = 1'b0;

  logic       txValid1 = 1'b0;
  logic [7:0] txData1 = 8'hB4;
  logic       txReady1, rxValid1, busy1, spiClk1, spiCsN1, spiMosi1;
  logic [7:0] rxData1;

  int checks = 0;
  int failures = 0;

  // Model state
  int         cyc = 0;
  int         t0 = 0;
  bit         frameActive = 1'b0;
  bit         loopAtStart = 1'b0;
  logic [7:0] txWord = '0;
  logic [7:0] slaveWord = '0;
  logic [7:0] expRxData = '0;
  int         startCount = 0;
  bit         forceSlaveEn = 1'b0;
  logic [7:0] forcedSlave = '0;

  // Monitors
  bit         prevClk = 1'b0, prevReady = 1'b0, prevCsN = 1'b1;
  int         riseCount = 0;
  logic [7:0] riseBits = '0;
  int         lastRxCyc = 0, readyCyc = 0, rxPulseCount = 0;
  int         csRun = 0, csHighRun = 0, mosiZeroCnt = 0;
  bit         prevBusy1 = 1'b0, prevReady1 = 1'b0, prevClk1 = 1'b0;
  int         hs1Cyc = 0, rx1Cyc = 0, ready1Cyc = 0, clk1Mismatch = 0, rise1Count = 0;

  assign spiMiso = loopMode ? spiMosi : misoDrv;

  spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .PClK(PClK), .PRESETn(PRESETn), .tx_valid(txValid), .tx_data(txData),
    .tx_ready(txReady), .rx_valid(rxValid), .rx_data(rxData), .busy(busy),
    .SPI_CLK(spiClk), .SPI_CS_n(spiCsN), .SPI_MOSI(spiMosi), .SPI_MISO(spiMiso)
  );

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) dut1 (
    .PClK(PClK), .PRESETn(PRESETn), .tx_valid(txValid1), .tx_data(txData1),
    .tx_ready(txReady1), .rx_valid(rxValid1), .rx_data(rxData1), .busy(busy1),
    .SPI_CLK(spiClk1), .SPI_CS_n(spiCsN1), .SPI_MOSI(spiMosi1), .SPI_MISO(spiMosi1)
  );

  // Free-running peripheral clock, 10 time units per period.
  always #5 PClK = ~PClK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic noteTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  task automatic tickDrive();
    @(posedge PClK);
    #2;
  endtask

  // Frame-level model: a handshake happens on an edge where the previous cycle was idle.
  always @(posedge PClK or negedge PRESETn) begin
    if (!PRESETn) begin
      frameActive = 1'b0;
      expRxData   = '0;
    end else begin
      cyc++;
      if (frameActive && (cyc - t0) == RXT)
        expRxData = loopAtStart ? txWord : slaveWord;
      if (!(frameActive && (cyc - 1 - t0) < L) && txValid) begin
        frameActive = 1'b1;
        t0          = cyc;
        txWord      = txData;
        slaveWord   = forceSlaveEn ? forcedSlave : 8'($urandom);
        loopAtStart = loopMode;
        startCount++;
      end
    end
  end

  // Slave model: presents bit k of its word for the whole cycle before SPI rise k.
  always @(posedge PClK) begin : slaveBlk
    int t;
    #2;
    t = cyc - t0;
    if (frameActive && t < 2 * DW * CD)
      misoDrv = slaveWord[DW - 1 - t / (2 * CD)];
    else
      misoDrv = 1'($urandom_range(0, 1));
  end

  // Compare every output against the model mid-cycle, and log frame events.
  always @(negedge PClK) begin : cmpBlk
    int   t;
    logic inF, eCs, eClk, eRxV, eMosi;
    t    = cyc - t0;
    inF  = frameActive && t < L;
    eCs  = !(frameActive && t < RXT);
    eClk = inF && t >= CD && t < (2 * DW + 1) * CD && (((t / CD) - 1) % 2 == 0);
    eRxV = frameActive && t == RXT;
    eMosi = (t < 2 * DW * CD) ? txWord[DW - 1 - t / (2 * CD)] : txWord[0];
    checkOutput("tx_ready", 32'(txReady), 32'(!inF));
    checkOutput("busy", 32'(busy), 32'(inF));
    checkOutput("cs_n", 32'(spiCsN), 32'(eCs));
    checkOutput("spi_clk", 32'(spiClk), 32'(eClk));
    checkOutput("rx_valid", 32'(rxValid), 32'(eRxV));
    checkOutput("rx_data", 32'(rxData), 32'(expRxData));
    if (!frameActive)
      checkOutput("mosi_idle", 32'(spiMosi), 32'(0));
    else if (!eCs)
      checkOutput("mosi", 32'(spiMosi), 32'(eMosi));

    if (spiClk && !prevClk) begin
      riseCount++;
      riseBits = {riseBits[6:0], spiMosi};
    end
    if (rxValid) begin
      lastRxCyc = cyc;
      rxPulseCount++;
    end
    if (txReady && !prevReady) readyCyc = cyc;
    if (spiCsN) csRun++;
    else begin
      if (prevCsN) csHighRun = csRun;
      csRun = 0;
      if (!spiMosi) mosiZeroCnt++;
    end
    prevClk   = spiClk;
    prevReady = txReady;
    prevCsN   = spiCsN;
  end

  // Fast-divider instance monitor: handshake, rx pulse, ready return and clock pattern.
  always @(negedge PClK) begin : mon1Blk
    int t;
    if (busy1 && !prevBusy1) hs1Cyc = cyc;
    if (busy1) begin
      t = cyc - hs1Cyc;
      if (spiClk1 !== ((t >= 1) && (t < 17) && (t % 2 == 1))) clk1Mismatch++;
    end
    if (spiClk1 && !prevClk1) rise1Count++;
    if (rxValid1) rx1Cyc = cyc;
    if (txReady1 && !prevReady1) ready1Cyc = cyc;
    prevBusy1  = busy1;
    prevClk1   = spiClk1;
    prevReady1 = txReady1;
  end

  task automatic clearLog();
    riseCount   = 0;
    riseBits    = '0;
    mosiZeroCnt = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] word, input bit loop, input bit hold, output int tStart);
    int n;
    int old;
    loopMode = loop;
    txData   = word;
    txValid  = 1'b1;
    old      = startCount;
    n        = 0;
    while (startCount == old && n < 200) begin
      tickDrive();
      n++;
    end
    if (startCount == old) noteTimeout("handshake");
    if (!hold) txValid = 1'b0;
    tStart = t0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!txReady && n < 300) begin
      tickDrive();
      n++;
    end
    if (!txReady) noteTimeout("frame_done");
    @(negedge PClK);
    #1;
  endtask

  initial begin : mainBlk
    int tS, tA, tB, old, rxBefore, n;

    repeat (3) @(posedge PClK);
    #2;
    checkOutput("reset tx_ready", 32'(txReady), 32'(1));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset cs_n", 32'(spiCsN), 32'(1));
    checkOutput("reset spi_clk", 32'(spiClk), 32'(0));
    checkOutput("reset mosi", 32'(spiMosi), 32'(0));
    checkOutput("reset rx_valid", 32'(rxValid), 32'(0));
    checkOutput("reset rx_data", 32'(rxData), 32'(0));
    PRESETn = 1'b1;
    repeat (3) tickDrive();

    // Loopback 0xA5: bits 1,0,1,0,0,1,0,1 at the rises, rx at +72, ready at +76.
    clearLog();
    applyStimulus(8'hA5, 1'b1, 1'b0, tS);
    waitDone();
    checkOutput("A rx_data", 32'(rxData), 32'h0000_00A5);
    checkOutput("A rx_valid time", 32'(lastRxCyc - tS), 32'd72);
    checkOutput("A ready time", 32'(readyCyc - tS), 32'd76);
    checkOutput("A clk pulses", 32'(riseCount), 32'd8);
    checkOutput("A mosi at rises", 32'(riseBits), 32'h0000_00A5);

    // Slave returns 0x3C while the master sends all ones.
    clearLog();
    forceSlaveEn = 1'b1;
    forcedSlave  = 8'h3C;
    applyStimulus(8'hFF, 1'b0, 1'b0, tS);
    waitDone();
    forceSlaveEn = 1'b0;
    checkOutput("B rx_data", 32'(rxData), 32'h0000_003C);
    checkOutput("B mosi zeros in frame", 32'(mosiZeroCnt), 32'd0);
    checkOutput("B mosi at rises", 32'(riseBits), 32'h0000_00FF);

    // Back-to-back with tx_valid held: the next handshake lands on the first idle cycle.
    rxBefore = rxPulseCount;
    applyStimulus(8'h01, 1'b1, 1'b1, tA);
    txData = 8'h80;
    old = startCount;
    n = 0;
    while (startCount == old && n < 200) begin
      tickDrive();
      n++;
    end
    if (startCount == old) noteTimeout("C second handshake");
    txValid = 1'b0;
    tB = t0;
    checkOutput("C handshake spacing", 32'(tB - tA), 32'(L + 1));
    checkOutput("C cs_n high run", 32'(csHighRun), 32'(CD + 1));
    waitDone();
    checkOutput("C rx_data", 32'(rxData), 32'h0000_0080);
    checkOutput("C rx pulses", 32'(rxPulseCount - rxBefore), 32'd2);

    // Asynchronous reset in the middle of bit 3.
    applyStimulus(8'h5A, 1'b1, 1'b0, tS);
    repeat (29) @(posedge PClK);
    #3;
    PRESETn = 1'b0;
    #1;
    checkOutput("D reset cs_n", 32'(spiCsN), 32'(1));
    checkOutput("D reset spi_clk", 32'(spiClk), 32'(0));
    checkOutput("D reset mosi", 32'(spiMosi), 32'(0));
    checkOutput("D reset tx_ready", 32'(txReady), 32'(1));
    rxBefore = rxPulseCount;
    repeat (3) @(posedge PClK);
    #2;
    PRESETn = 1'b1;
    repeat (100) tickDrive();
    checkOutput("D no rx after reset", 32'(rxPulseCount - rxBefore), 32'd0);

    // A normal frame right after the aborted one.
    applyStimulus(8'hC3, 1'b1, 1'b0, tS);
    waitDone();
    checkOutput("E rx_data", 32'(rxData), 32'h0000_00C3);
    checkOutput("E rx_valid time", 32'(lastRxCyc - tS), 32'd72);

    // Requests while busy are ignored.
    clearLog();
    old = startCount;
    applyStimulus(8'h96, 1'b1, 1'b0, tS);
    repeat (20) tickDrive();
    txValid = 1'b1;
    txData  = 8'h00;
    repeat (3) tickDrive();
    txValid = 1'b0;
    waitDone();
    repeat (4) tickDrive();
    checkOutput("F frames started", 32'(startCount - old), 32'd1);
    checkOutput("F mosi at rises", 32'(riseBits), 32'h0000_0096);
    checkOutput("F rx_data", 32'(rxData), 32'h0000_0096);

    // CLK_DIV=1 instance: SPI_CLK toggles every cycle, rx at +18, ready at +19.
    txValid1 = 1'b1;
    n = 0;
    while (!busy1 && n < 20) begin
      tickDrive();
      n++;
    end
    if (!busy1) noteTimeout("G handshake");
    txValid1 = 1'b0;
    n = 0;
    while (!txReady1 && n < 60) begin
      tickDrive();
      n++;
    end
    if (!txReady1) noteTimeout("G frame_done");
    @(negedge PClK);
    #1;
    checkOutput("G rx_valid time", 32'(rx1Cyc - hs1Cyc), 32'd18);
    checkOutput("G ready time", 32'(ready1Cyc - hs1Cyc), 32'd19);
    checkOutput("G rx_data", 32'(rxData1), 32'h0000_00B4);
    checkOutput("G clk pattern errors", 32'(clk1Mismatch), 32'd0);
    checkOutput("G clk pulses", 32'(rise1Count), 32'd8);

    // Random traffic against the model, including requests while busy.
    loopMode = 1'b0;
    repeat (3000) begin
      txValid = 1'($urandom_range(0, 1));
      txData  = 8'($urandom);
      tickDrive();
    end
    txValid = 1'b0;
    waitDone();
    repeat (5) tickDrive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
